// File: rtl/tick_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// tick_scheduler_pkg
// Shared definitions for the tick scheduler:
//   - mode_e        : configuration mode encoding carried on cfg_mode
//   - state_e       : scheduler FSM states
//   - DEFAULT_DIV_C : divisor loaded at reset (10 Hz tick from a 74 MHz clock)
//   - mode_to_state : maps a valid mode onto the state it starts
// ----------------------------------------------------------------------------
package tick_scheduler_pkg;

    localparam int unsigned DEFAULT_DIV_C = 7400000;

    typedef enum logic [1:0] {
        MODE_STOP    = 2'b00,
        MODE_RUN     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_ONESHOT = 2'b10
    } state_e;

    function automatic state_e mode_to_state(input mode_e m);
        case (m)
            MODE_RUN:     return ST_RUN;
            MODE_ONESHOT: return ST_ONESHOT;
            default:      return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tick_scheduler.sv
// ----------------------------------------------------------------------------
// tick_scheduler
// Programmable period generator. A configuration (divisor + mode) is accepted
// through a valid/ready handshake. In IDLE it starts immediately; while running
// it is parked in shadow registers and takes effect on the next tick edge, so
// a period is never truncated or stretched.
//
// Ports
//   clk_74    in   single clock, rising edge
//   reset     in   asynchronous, active-high reset
//   cfg_valid in   configuration request valid
//   cfg_ready out  configuration can be accepted this cycle
//   cfg_div   in   requested period in clk_74 cycles (0 is rejected)
//   cfg_mode  in   00 stop, 01 continuous, 10 one-shot, 11 reserved (rejected)
//   tick      out  registered one-cycle pulse per period (constant high at div 1)
//   clk_out   out  square wave toggling on every tick
//   busy      out  state is not IDLE
//   err       out  one-cycle pulse after a rejected configuration
// ----------------------------------------------------------------------------
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
    input  logic             clk_74,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_sh_div;
    mode_e            r_sh_mode;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;
    logic             r_err;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_sh_div_nxt;
    mode_e            w_sh_mode_nxt;
    logic             w_pending_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic             w_err_nxt;

    mode_e            w_cfg_mode;
    logic             w_ready;
    logic             w_accept;
    logic             w_cfg_bad;
    logic             w_cfg_ok;

    assign w_cfg_mode = mode_e'(cfg_mode);
    assign w_ready    = (r_state == ST_IDLE) || !r_pending;
    assign w_accept   = cfg_valid && w_ready;
    assign w_cfg_bad  = (cfg_div == '0) || (w_cfg_mode == MODE_RSVD);
    assign w_cfg_ok   = w_accept && !w_cfg_bad;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_sh_div_nxt  = r_sh_div;
        w_sh_mode_nxt = r_sh_mode;
        w_pending_nxt = r_pending;
        w_clk_nxt     = r_clk_out;
        w_err_nxt     = w_accept && w_cfg_bad;

        case (r_state)
            ST_IDLE: begin
                if (w_cfg_ok) begin
                    w_div_nxt   = cfg_div;
                    w_cnt_nxt   = '0;
                    w_state_nxt = mode_to_state(w_cfg_mode);
                end
            end
            default: begin
                // r_tick high means the counter sits on div_q-1: this edge
                // closes the period, so it is the only place div_q may change.
                if (r_tick) begin
                    w_cnt_nxt = '0;
                    w_clk_nxt = ~r_clk_out;
                    if (r_pending) begin
                        w_div_nxt     = r_sh_div;
                        w_state_nxt   = mode_to_state(r_sh_mode);
                        w_pending_nxt = 1'b0;
                    end else if (r_state == ST_ONESHOT) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end

                // Acceptance here implies the pending flag was clear, so the
                // shadow is free. The one exception is a one-shot finishing on
                // this very edge: there is no later tick to defer to, so the
                // request starts a fresh period just as it would from IDLE.
                if (w_cfg_ok) begin
                    if (w_state_nxt == ST_IDLE) begin
                        w_div_nxt   = cfg_div;
                        w_cnt_nxt   = '0;
                        w_state_nxt = mode_to_state(w_cfg_mode);
                    end else begin
                        w_sh_div_nxt  = cfg_div;
                        w_sh_mode_nxt = w_cfg_mode;
                        w_pending_nxt = 1'b1;
                    end
                end
            end
        endcase

        // Tick is registered from next-state values so it lines up exactly
        // with the cycle in which the counter holds div_q-1.
        w_tick_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt == (w_div_nxt - ONE));
    end

    always_ff @(posedge clk_74 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= DIV_RST;
            r_sh_div  <= '0;
            r_sh_mode <= MODE_STOP;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_sh_div  <= w_sh_div_nxt;
            r_sh_mode <= w_sh_mode_nxt;
            r_pending <= w_pending_nxt;
            r_tick    <= w_tick_nxt;
            r_clk_out <= w_clk_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign cfg_ready = w_ready;
    assign tick      = r_tick;
    assign clk_out   = r_clk_out;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_tick_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tick_scheduler
// Table-driven bench for tick_scheduler: each record holds the configuration
// driven before a rising edge and the outputs expected just after it. The
// reset and post-reset corners are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_tick_scheduler;

    logic        clk_74;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_div;
    logic [1:0]  cfg_mode;
    logic        tick;
    logic        clk_out;
    logic        busy;
    logic        err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        vld;
        logic [31:0] div;
        logic [1:0]  mode;
        logic        e_tick;
        logic        e_clk;
        logic        e_busy;
        logic        e_err;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[$];

    tick_scheduler #(
        .CNT_W       (32),
        .DEFAULT_DIV (7400000)
    ) dut (
        .clk_74    (clk_74),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy),
        .err       (err)
    );

    initial clk_74 = 1'b0;
    always #5 clk_74 = ~clk_74;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic [1:0] m,
                       input logic t, input logic c, input logic b, input logic e, input logic r);
        vec_t x;
        x.vld = v; x.div = d; x.mode = m;
        x.e_tick = t; x.e_clk = c; x.e_busy = b; x.e_err = e; x.e_rdy = r;
        vecs.push_back(x);
    endtask

    task automatic chk_outs(input string tag, input logic t, input logic c,
                            input logic b, input logic e, input logic r);
        chk({tag, " tick"},      tick,      t);
        chk({tag, " clk_out"},   clk_out,   c);
        chk({tag, " busy"},      busy,      b);
        chk({tag, " err"},       err,       e);
        chk({tag, " cfg_ready"}, cfg_ready, r);
    endtask

    task automatic idle_step();
        @(negedge clk_74);
        cfg_valid = 1'b0;
        @(posedge clk_74);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_mode  = 2'b00;

        //          vld div mode   tick clk busy err rdy  (after the edge)
        // continuous, div 4: ticks every 4 cycles, clk_out toggles on each
        add(1, 4, 2'b01, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        add(0, 0, 2'b00, 1, 1, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        // re-program to div 5 while running: pending until the div-4 tick
        add(1, 5, 2'b01, 0, 1, 1, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 0, 0);
        add(0, 0, 2'b00, 1, 1, 1, 0, 0);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        // div 5, accept div 2 while counter is 1: period 5 finishes, then 2
        add(1, 2, 2'b01, 0, 0, 1, 0, 0);
        add(0, 0, 2'b00, 0, 0, 1, 0, 0);
        add(0, 0, 2'b00, 1, 0, 1, 0, 0);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        add(0, 0, 2'b00, 1, 1, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        // div 1: tick constantly high, clk_out toggles every cycle
        add(1, 1, 2'b01, 1, 1, 1, 0, 0);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 1, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        // stop accepted on a tick edge: deferred one tick, then IDLE
        add(1, 9, 2'b00, 1, 1, 1, 0, 0);
        add(0, 0, 2'b00, 0, 0, 0, 0, 1);
        add(0, 0, 2'b00, 0, 0, 0, 0, 1);
        // one-shot div 3 from IDLE: single tick, then idle with clk_out held
        add(1, 3, 2'b10, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 0, 0, 1);
        add(0, 0, 2'b00, 0, 1, 0, 0, 1);
        add(0, 0, 2'b00, 0, 1, 0, 0, 1);
        // rejected configurations in IDLE: err pulses, stays idle
        add(1, 0, 2'b01, 0, 1, 0, 1, 1);
        add(1, 4, 2'b11, 0, 1, 0, 1, 1);
        add(0, 0, 2'b00, 0, 1, 0, 0, 1);
        // rejected configurations while running div 3: period stays 3
        add(1, 3, 2'b01, 0, 1, 1, 0, 1);
        add(1, 0, 2'b01, 0, 1, 1, 1, 1);
        add(1, 4, 2'b11, 1, 1, 1, 1, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 0, 1, 0, 1);
        add(0, 0, 2'b00, 1, 0, 1, 0, 1);
        add(0, 0, 2'b00, 0, 1, 1, 0, 1);
        // leave a one-shot pending for the asynchronous reset below
        add(1, 7, 2'b10, 0, 1, 1, 0, 0);

        // reset state, with reset held across a clock edge
        @(posedge clk_74);
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset div_q", dut.r_div, 32'd7400000);
        @(negedge clk_74);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_74);
            cfg_valid = vecs[i].vld;
            cfg_div   = vecs[i].div;
            cfg_mode  = vecs[i].mode;
            @(posedge clk_74);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_clk,
                     vecs[i].e_busy, vecs[i].e_err, vecs[i].e_rdy);
        end

        // asynchronous reset mid-period with a configuration pending
        #2;
        cfg_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("async_rst div_q",   dut.r_div,     32'd7400000);
        chk("async_rst pending", dut.r_pending, 32'd0);

        // configuration accepted on the first edge after reset release
        @(negedge clk_74);
        reset     = 1'b0;
        cfg_valid = 1'b1;
        cfg_div   = 32'd2;
        cfg_mode  = 2'b01;
        @(posedge clk_74);
        #1;
        chk_outs("post_rst accept", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_step();
        chk_outs("post_rst tick", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_step();
        chk_outs("post_rst wrap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
